// File: rtl/data_mem_responder.sv
// Word-addressed data RAM responder for the CPU data port; optional debug read port under DATA_MEM_DEBUG_EN.
// Latency: response pulse WAIT_CYCLES+1 cycles after acceptance; error response one cycle after acceptance.
// Backpressure: busy is high from acceptance through the response cycle, and requests are ignored while it is high.
module data_mem_responder #(
    parameter int    ADDR_WIDTH  = 10,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_ren,
    input  logic                  req_wen,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
`ifdef DATA_MEM_DEBUG_EN
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [31:0]           debug_data,
`endif
    output logic [31:0]           resp_rdata,
    output logic                  resp_ready,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_wdata;
    logic                  lat_wen;

    logic [31:0]           mem [0:DEPTH-1];

    logic                  req_any;
    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  ram_we;

    assign req_any = req_ren | req_wen;
    assign req_idx = req_addr[ADDR_WIDTH+1:2];
    // Out-of-range addresses are rejected rather than aliased onto the RAM.
    assign req_bad = (req_ren & req_wen)
                   | (req_addr[1:0] != 2'b00)
                   | ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // Writes land on the edge that ends the RESP cycle, so a reset during WAIT drops them.
    assign ram_we = (state == S_RESP) && lat_wen;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

`ifdef DATA_MEM_DEBUG_EN
    always_ff @(posedge clk) begin
        debug_data <= mem[debug_addr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_idx    <= '0;
            lat_wdata  <= 32'd0;
            lat_wen    <= 1'b0;
            resp_rdata <= 32'd0;
            resp_ready <= 1'b0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_ready <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        lat_idx   <= req_idx;
                        lat_wdata <= req_wdata;
                        lat_wen   <= req_wen;
                        cnt       <= WAIT_LD;
                        busy      <= 1'b1;
                        if (req_bad) begin
                            state      <= S_ERR;
                            resp_ready <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state      <= S_RESP;
                            resp_ready <= 1'b1;
                            if (!req_wen) begin
                                resp_rdata <= mem[req_idx];
                            end
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt <= 4'd1) begin
                        cnt        <= 4'd0;
                        state      <= S_RESP;
                        resp_ready <= 1'b1;
                        if (!lat_wen) begin
                            resp_rdata <= mem[lat_idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
